// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: one-cycle start pulse per enabled stage, per-stage finish
// handshake, stage skipping by a per-instruction mask, hung-stage abort and delayed commit strobe.
module multicycle_sequencer #(
    parameter int unsigned NSTAGES      = 4,
    parameter int unsigned COMMIT_DELAY = 2,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned CNT_W        = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       halt,
    input  logic [NSTAGES-1:0]         stage_finish,
    input  logic [NSTAGES-1:0]         stage_mask,
    output logic [NSTAGES-1:0]         stage_valid,
    output logic [$clog2(NSTAGES)-1:0] cur_stage,
    output logic                       busy,
    output logic                       commit,
    output logic                       commit_dly,
    output logic [CNT_W-1:0]           instret,
    output logic                       timeout_err
);
    localparam int unsigned SW = $clog2(NSTAGES);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StWb} state_t;

    state_t             r_state;
    logic [NSTAGES-1:0] r_mask;
    logic [NSTAGES-1:0] r_stage_valid;
    logic [SW-1:0]      r_cur;
    logic [TW-1:0]      r_timer;
    logic               r_busy;
    logic               r_commit;
    logic               r_err;
    logic [CNT_W-1:0]   r_instret;

    logic [NSTAGES-1:0] w_mask;
    logic               w_fin;
    logic               w_expire;
    logic               w_found;
    logic [SW-1:0]      w_next;

    // The mask is latched at the stage-0 finish edge, so the skip decision there uses the input.
    assign w_mask   = (r_cur == '0) ? (stage_mask | NSTAGES'(1)) : r_mask;
    assign w_fin    = stage_finish[r_cur];
    assign w_expire = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));

    // Descending scan so the lowest enabled stage above the current one wins.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        for (int j = NSTAGES - 1; j >= 0; j--) begin
            if (w_mask[j] && (j > int'(r_cur))) begin
                w_found = 1'b1;
                w_next  = SW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_mask        <= '1;
            r_stage_valid <= '0;
            r_cur         <= '0;
            r_timer       <= '0;
            r_busy        <= 1'b0;
            r_commit      <= 1'b0;
            r_err         <= 1'b0;
            r_instret     <= '0;
        end else begin
            r_stage_valid <= '0;
            r_commit      <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (!halt) begin
                        r_state       <= StRun;
                        r_cur         <= '0;
                        r_stage_valid <= NSTAGES'(1);
                        r_timer       <= '0;
                        r_busy        <= 1'b1;
                    end
                end
                StRun: begin
                    if (w_fin) begin
                        if (r_cur == '0) r_mask <= stage_mask | NSTAGES'(1);
                        r_timer <= '0;
                        if (w_found) begin
                            r_cur         <= w_next;
                            r_stage_valid <= NSTAGES'(1) << w_next;
                        end else begin
                            r_state  <= StWb;
                            r_commit <= 1'b1;
                        end
                    end else if (w_expire) begin
                        // Abandon the hung instruction without committing it.
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                StWb: begin
                    r_state   <= StIdle;
                    r_busy    <= 1'b0;
                    r_instret <= r_instret + CNT_W'(1);
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    generate
        if (COMMIT_DELAY == 0) begin : g_no_dly
            assign commit_dly = r_commit;
        end else begin : g_dly
            logic [COMMIT_DELAY-1:0] r_dly;
            always_ff @(posedge clk) begin
                if (rst) r_dly <= '0;
                else     r_dly <= (r_dly << 1) | COMMIT_DELAY'(r_commit);
            end
            assign commit_dly = r_dly[COMMIT_DELAY-1];
        end
    endgenerate

    assign stage_valid = r_stage_valid;
    assign cur_stage   = r_cur;
    assign busy        = r_busy;
    assign commit      = r_commit;
    assign instret     = r_instret;
    assign timeout_err = r_err;

endmodule
